// File: rtl/inertial_rd_seq_if.sv
// Sensor-sequencer bus: SPI master handshake, interrupt input and decoded outputs.
// "master" is the sequencer side; "slave" is the SPI master / sensor / consumer side.
interface inertial_rd_seq_if;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;
  logic        cfg_done;

  modport master (
    input  INT, done, rd_data,
    output wrt, cmd, ptch_rt, AZ, vld, cfg_done
  );

  modport slave (
    output INT, done, rd_data,
    input  wrt, cmd, ptch_rt, AZ, vld, cfg_done
  );
endinterface

// File: rtl/inertial_rd_seq.sv
// Inertial sensor sequencer: one-time SPI register configuration, then a 4-byte
// readout per data-ready interrupt, assembled into signed pitch rate and Z accel.
module inertial_rd_seq #(
  parameter int          INIT_WAIT_BITS = 16,
  parameter logic [15:0] CFG0 = 16'h0D02,
  parameter logic [15:0] CFG1 = 16'h1053,
  parameter logic [15:0] CFG2 = 16'h1150,
  parameter logic [15:0] CFG3 = 16'h1460
) (
  input logic               clk,
  input logic               rst,
  inertial_rd_seq_if.master bus
);

  typedef enum logic [2:0] {
    INIT_WAIT,
    CFG,
    CFG_WAIT,
    IDLE,
    RD,
    RD_WAIT,
    VLD
  } state_t;

  state_t                    state_reg, state_next;
  logic [INIT_WAIT_BITS-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]                idx_reg, idx_next;
  logic [7:0]                byte_reg [4];
  logic [7:0]                byte_next [4];
  logic [15:0]               cmd_reg, cmd_next;
  logic [15:0]               ptch_reg, ptch_next;
  logic [15:0]               az_reg, az_next;
  logic                      cfg_done_reg, cfg_done_next;
  logic                      pending_reg, pending_next;
  logic                      sync1_reg, sync2_reg, sync3_reg;
  logic                      int_rise;
  logic                      wrt;
  logic                      vld;
  logic [7:0]                unused_rd_hi;

  function automatic logic [15:0] cfg_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CFG0;
      2'd1:    return CFG1;
      2'd2:    return CFG2;
      default: return CFG3;
    endcase
  endfunction

  // Read order: pitch low, pitch high, AZ low, AZ high.
  function automatic logic [15:0] rd_cmd(input logic [1:0] j);
    case (j)
      2'd0:    return 16'hA200;
      2'd1:    return 16'hA300;
      2'd2:    return 16'hAC00;
      default: return 16'hAD00;
    endcase
  endfunction

  assign int_rise     = sync2_reg & ~sync3_reg;
  assign unused_rd_hi = bus.rd_data[15:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= INIT_WAIT;
      wait_cnt_reg <= '0;
      idx_reg      <= '0;
      for (int k = 0; k < 4; k++) byte_reg[k] <= '0;
      cmd_reg      <= '0;
      ptch_reg     <= '0;
      az_reg       <= '0;
      cfg_done_reg <= 1'b0;
      pending_reg  <= 1'b0;
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      sync3_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      idx_reg      <= idx_next;
      for (int k = 0; k < 4; k++) byte_reg[k] <= byte_next[k];
      cmd_reg      <= cmd_next;
      ptch_reg     <= ptch_next;
      az_reg       <= az_next;
      cfg_done_reg <= cfg_done_next;
      pending_reg  <= pending_next;
      sync1_reg    <= bus.INT;
      sync2_reg    <= sync1_reg;
      sync3_reg    <= sync2_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    idx_next      = idx_reg;
    for (int k = 0; k < 4; k++) byte_next[k] = byte_reg[k];
    cmd_next      = cmd_reg;
    ptch_next     = ptch_reg;
    az_next       = az_reg;
    cfg_done_next = cfg_done_reg;
    pending_next  = pending_reg;
    wrt           = 1'b0;
    vld           = 1'b0;

    // cmd is loaded on entry to CFG/RD so it is already valid in the wrt cycle.
    case (state_reg)
      INIT_WAIT: begin
        wait_cnt_next = wait_cnt_reg + {{(INIT_WAIT_BITS-1){1'b0}}, 1'b1};
        if (&wait_cnt_reg) begin
          state_next = CFG;
          idx_next   = 2'd0;
          cmd_next   = cfg_cmd(2'd0);
        end
      end
      CFG: begin
        wrt        = 1'b1;
        state_next = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (bus.done) begin
          if (idx_reg == 2'd3) begin
            cfg_done_next = 1'b1;
            state_next    = IDLE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            cmd_next   = cfg_cmd(idx_reg + 2'd1);
            state_next = CFG;
          end
        end
      end
      IDLE: begin
        if (int_rise || pending_reg) begin
          pending_next = 1'b0;
          idx_next     = 2'd0;
          cmd_next     = rd_cmd(2'd0);
          state_next   = RD;
        end
      end
      RD: begin
        wrt        = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.done) begin
          byte_next[idx_reg] = bus.rd_data[7:0];
          if (idx_reg == 2'd3) begin
            // Final byte bypasses its register so outputs are valid in the vld cycle.
            ptch_next  = {byte_reg[1], byte_reg[0]};
            az_next    = {bus.rd_data[7:0], byte_reg[2]};
            state_next = VLD;
          end else begin
            idx_next   = idx_reg + 2'd1;
            cmd_next   = rd_cmd(idx_reg + 2'd1);
            state_next = RD;
          end
        end
      end
      VLD: begin
        vld        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = INIT_WAIT;
    endcase

    if (int_rise && cfg_done_reg &&
        (state_reg == RD || state_reg == RD_WAIT || state_reg == VLD))
      pending_next = 1'b1;
  end

  assign bus.wrt      = wrt;
  assign bus.vld      = vld;
  assign bus.cmd      = cmd_reg;
  assign bus.ptch_rt  = ptch_reg;
  assign bus.AZ       = az_reg;
  assign bus.cfg_done = cfg_done_reg;

endmodule

// File: tb/tb_inertial_rd_seq.sv
// Directed bench for inertial_rd_seq: SPI model answering 10 cycles after wrt,
// table-driven config/read checks plus hand-written multi-cycle corner cases.
module tb_inertial_rd_seq;

  localparam int SPI_LAT = 10;

  typedef struct {
    logic [15:0] cmd;
    int          cyc;
  } cfg_vec_t;

  typedef struct {
    logic [31:0] bytes;   // {b3, b2, b1, b0}
    logic [15:0] exp_pr;
    logic [15:0] exp_az;
  } rd_vec_t;

  logic clk;
  logic rst;

  inertial_rd_seq_if bus ();

  inertial_rd_seq #(.INIT_WAIT_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Logs written only by the model/monitor process
  int          wrt_cyc_q[$];
  logic [15:0] wrt_cmd_q[$];
  int          vld_cyc_q[$];
  logic [15:0] vld_pr_q[$];
  logic [15:0] vld_az_q[$];
  int          cfg_rise_cyc = -1;
  int          consec_wrt = 0;
  logic        prev_wrt = 1'b0;
  logic        prev_cfg = 1'b0;
  int          spi_cnt = 0;
  logic [15:0] spi_cmd = 16'h0;
  int          stray_ack = 0;

  // Written only by the main process
  logic [7:0]  rb [4];
  int          stray_req = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [7:0] model_byte(input logic [15:0] c);
    case (c[15:8])
      8'hA2:   return rb[0];
      8'hA3:   return rb[1];
      8'hAC:   return rb[2];
      8'hAD:   return rb[3];
      default: return 8'h00;
    endcase
  endfunction

  // SPI slave model and monitor, evaluated mid-cycle
  always @(negedge clk) begin
    bus.done    = 1'b0;
    bus.rd_data = 16'hDEAD;
    if (stray_req != stray_ack) begin
      stray_ack   = stray_req;
      bus.done    = 1'b1;
      bus.rd_data = 16'h55FF;
    end else if (spi_cnt != 0) begin
      spi_cnt = spi_cnt - 1;
      if (spi_cnt == 0) begin
        bus.done    = 1'b1;
        bus.rd_data = {8'h5A, model_byte(spi_cmd)};
      end
    end
    if (bus.wrt === 1'b1 && !rst) begin
      spi_cnt = SPI_LAT;
      spi_cmd = bus.cmd;
      wrt_cyc_q.push_back(cyc);
      wrt_cmd_q.push_back(bus.cmd);
      if (prev_wrt) consec_wrt = consec_wrt + 1;
      $display("wrt  cyc=%0d cmd=%h", cyc, bus.cmd);
    end
    prev_wrt = bus.wrt;
    if (bus.vld === 1'b1) begin
      vld_cyc_q.push_back(cyc);
      vld_pr_q.push_back(bus.ptch_rt);
      vld_az_q.push_back(bus.AZ);
      $display("vld  cyc=%0d ptch_rt=%h AZ=%h", cyc, bus.ptch_rt, bus.AZ);
    end
    if (rst) cfg_rise_cyc = -1;
    else if (bus.cfg_done && !prev_cfg) cfg_rise_cyc = cyc;
    prev_cfg = bus.cfg_done;
  end

  function automatic int wcyc(input int i);
    return (i < wrt_cyc_q.size()) ? wrt_cyc_q[i] : -1;
  endfunction
  function automatic logic [15:0] wcmd(input int i);
    return (i < wrt_cmd_q.size()) ? wrt_cmd_q[i] : 16'hXXXX;
  endfunction
  function automatic int vcyc(input int i);
    return (i < vld_cyc_q.size()) ? vld_cyc_q[i] : -1;
  endfunction
  function automatic logic [15:0] vpr(input int i);
    return (i < vld_pr_q.size()) ? vld_pr_q[i] : 16'hXXXX;
  endfunction
  function automatic logic [15:0] vaz(input int i);
    return (i < vld_az_q.size()) ? vld_az_q[i] : 16'hXXXX;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_int(output int c);
    c = cyc;
    bus.INT = 1'b1;
    tick(3);
    bus.INT = 1'b0;
  endtask

  task automatic wait_vld(input int target, input int budget);
    int n = 0;
    while (vld_cyc_q.size() < target && n < budget) begin
      tick(1);
      n++;
    end
    check("vld_wait", 32'(vld_cyc_q.size() >= target), 32'd1);
  endtask

  task automatic wait_cfg(input int budget);
    int n = 0;
    while (bus.cfg_done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check("cfg_wait", 32'(bus.cfg_done), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wrt"},      32'(bus.wrt),      32'd0);
    check({tag, "_vld"},      32'(bus.vld),      32'd0);
    check({tag, "_ptch_rt"},  32'(bus.ptch_rt),  32'd0);
    check({tag, "_AZ"},       32'(bus.AZ),       32'd0);
    check({tag, "_cmd"},      32'(bus.cmd),      32'd0);
    check({tag, "_cfg_done"}, 32'(bus.cfg_done), 32'd0);
  endtask

  cfg_vec_t cfg_tab [4];
  rd_vec_t  rd_tab [3];
  logic [15:0] rd_cmds [4];

  // Config writes land every 1 + SPI_LAT cycles starting at cycle 16.
  task automatic check_cfg(input int base);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cfg%0d_cmd", k), 32'(wcmd(base + k)), 32'(cfg_tab[k].cmd));
      check($sformatf("cfg%0d_cyc", k), 32'(wcyc(base + k)), 32'(cfg_tab[k].cyc));
    end
    check("cfg_done_rise_cyc", 32'(cfg_rise_cyc), 32'd60);
    check("cfg_wrt_count", 32'(wrt_cyc_q.size()), 32'(base + 4));
  endtask

  initial begin
    int c, c2, vbase, wbase, n;
    logic stable;

    cfg_tab[0] = '{16'h0D02, 16};
    cfg_tab[1] = '{16'h1053, 27};
    cfg_tab[2] = '{16'h1150, 38};
    cfg_tab[3] = '{16'h1460, 49};
    rd_tab[0]  = '{32'hABCD1234, 16'h1234, 16'hABCD};
    rd_tab[1]  = '{32'h80017F80, 16'h7F80, 16'h8001};
    rd_tab[2]  = '{32'hFF60FF00, 16'hFF00, 16'hFF60};
    rd_cmds[0] = 16'hA200;
    rd_cmds[1] = 16'hA300;
    rd_cmds[2] = 16'hAC00;
    rd_cmds[3] = 16'hAD00;
    for (int k = 0; k < 4; k++) rb[k] = 8'h00;

    bus.INT = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(3);
    check_outputs_zero("reset");

    // Release, with INT pulses in INIT_WAIT and during configuration
    rst = 1'b0;
    tick(4);
    pulse_int(c);
    while (cyc < 30) tick(1);
    pulse_int(c);
    while (cyc < 50) tick(1);
    pulse_int(c);
    wait_cfg(200);
    tick(30);
    check_cfg(0);
    check("cfg_no_vld", 32'(vld_cyc_q.size()), 32'd0);

    // Single reads: wrt 3 cycles after INT is driven, vld 44 cycles after that
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 4; k++) rb[k] = rd_tab[v].bytes[8*k +: 8];
      vbase = vld_cyc_q.size();
      wbase = wrt_cyc_q.size();
      pulse_int(c);
      wait_vld(vbase + 1, 200);
      tick(20);
      check($sformatf("rd%0d_vld_count", v), 32'(vld_cyc_q.size()), 32'(vbase + 1));
      check($sformatf("rd%0d_ptch_rt", v), 32'(vpr(vbase)), 32'(rd_tab[v].exp_pr));
      check($sformatf("rd%0d_AZ", v), 32'(vaz(vbase)), 32'(rd_tab[v].exp_az));
      for (int k = 0; k < 4; k++)
        check($sformatf("rd%0d_cmd%0d", v, k), 32'(wcmd(wbase + k)), 32'(rd_cmds[k]));
      check($sformatf("rd%0d_first_wrt_cyc", v), 32'(wcyc(wbase)), 32'(c + 3));
      check($sformatf("rd%0d_vld_cyc", v), 32'(vcyc(vbase)), 32'(c + 47));
      check($sformatf("rd%0d_hold_pr", v), 32'(bus.ptch_rt), 32'(rd_tab[v].exp_pr));
    end

    // Negative values must hold with no INT for 100 cycles
    vbase = vld_cyc_q.size();
    wbase = wrt_cyc_q.size();
    stable = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (bus.ptch_rt !== 16'hFF00 || bus.AZ !== 16'hFF60 || bus.vld !== 1'b0) stable = 1'b0;
    end
    check("hold100_stable", 32'(stable), 32'd1);
    check("hold100_no_vld", 32'(vld_cyc_q.size()), 32'(vbase));
    check("hold100_no_wrt", 32'(wrt_cyc_q.size()), 32'(wbase));

    // Two extra INT rises during one read merge into one follow-up read
    rb[0] = 8'h44; rb[1] = 8'h33; rb[2] = 8'h22; rb[3] = 8'h11;
    vbase = vld_cyc_q.size();
    wbase = wrt_cyc_q.size();
    pulse_int(c);
    tick(10);
    pulse_int(c2);
    tick(10);
    pulse_int(c2);
    wait_vld(vbase + 2, 400);
    tick(100);
    check("dbl_vld_count", 32'(vld_cyc_q.size()), 32'(vbase + 2));
    check("dbl_wrt_count", 32'(wrt_cyc_q.size()), 32'(wbase + 8));
    check("dbl_second_wrt_gap", 32'(wcyc(wbase + 4)), 32'(vcyc(vbase) + 2));
    check("dbl_pr0", 32'(vpr(vbase)), 32'h3344);
    check("dbl_az1", 32'(vaz(vbase + 1)), 32'h1122);

    // Reset while waiting on the AZ low byte
    vbase = vld_cyc_q.size();
    wbase = wrt_cyc_q.size();
    pulse_int(c);
    n = 0;
    while (wrt_cyc_q.size() < wbase + 3 && n < 200) begin
      tick(1);
      n++;
    end
    check("rst_reached_j2", 32'(wcmd(wbase + 2)), 32'hAC00);
    tick(3);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    stray_req = stray_req + 1;
    tick(2);
    check_outputs_zero("stray");
    rst = 1'b0;
    wbase = wrt_cyc_q.size();
    wait_cfg(200);
    tick(30);
    check_cfg(wbase);
    check("rst_no_vld", 32'(vld_cyc_q.size()), 32'(vbase));
    check("rst_ptch_rt", 32'(bus.ptch_rt), 32'd0);
    check("rst_AZ", 32'(bus.AZ), 32'd0);

    check("wrt_never_back_to_back", 32'(consec_wrt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
